// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: address windows, cycle-type tags and
// the arbiter FSM state type.
package wb_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] size;
    } wb_addr_range;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 classic/registered-feedback bus bundle.
interface wishbone_b3 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m2s;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic [DATA_WIDTH-1:0]   dat_s2m;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output cyc, stb, we, adr, dat_m2s, sel, cti, bte,
        input  dat_s2m, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m2s, sel, cti, bte,
        output dat_s2m, ack, err, rty
    );
endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester found scanning
// ptr+1, ptr+2, ... modulo N.
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] pick
);
    localparam logic [IW:0] NW = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] idx_arr [N];

    // rot[k] is the request of the master k+1 positions after ptr
    for (genvar k = 0; k < N; k++) begin : g_scan
        logic [IW:0] sum;
        logic [IW:0] wrap;
        assign sum        = {1'b0, ptr} + (IW+1)'(k + 1);
        assign wrap       = (sum >= NW) ? (sum - NW) : sum;
        assign idx_arr[k] = wrap[IW-1:0];
        assign rot[k]     = req[idx_arr[k]];
    end

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !valid) begin
                valid = 1'b1;
                pick  = idx_arr[k];
            end
        end
    end
endmodule

// File: rtl/wb_arbiter_rr_b3.sv
// N-master Wishbone B3 arbiter: registered round-robin grant held for the
// whole CYC, with a per-transfer watchdog that ends hung strobes with ERR.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner, slave bus quiet, arbitrating among CYC requests
// ST_OWNED | master[ptr] owns the bus, combinational pass-through
// ST_ABORT | one-cycle watchdog termination: ERR to owner, slave CYC low
module wb_arbiter_rr_b3
    import wb_pkg::*;
#(
    parameter int MASTERS    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    wishbone_b3.slave          master [MASTERS],
    wishbone_b3.master         slave,
    output logic [MASTERS-1:0] grant,
    output logic               timeout
);
    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW = DATA_WIDTH / 8;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WW-1:0] WD_MAX  = '1;
    localparam logic [PW-1:0] PTR_RST = PW'(MASTERS - 1);
    localparam bit            WD_EN   = (TIMEOUT > 0);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [MASTERS-1:0]    cyc_vec, stb_vec, we_vec, is_own;
    logic [ADDR_WIDTH-1:0] adr_arr [MASTERS];
    logic [DATA_WIDTH-1:0] dat_arr [MASTERS];
    logic [SW-1:0]         sel_arr [MASTERS];
    logic [2:0]            cti_arr [MASTERS];
    logic [1:0]            bte_arr [MASTERS];

    logic          live, aborting, own_cyc, own_stb;
    logic          unanswered, wd_fire, pick_valid;
    logic [PW-1:0] pick_idx;

    assign live     = (state_q == ST_OWNED);
    assign aborting = (state_q == ST_ABORT);
    assign own_cyc  = cyc_vec[ptr_q];
    assign own_stb  = stb_vec[ptr_q];

    for (genvar i = 0; i < MASTERS; i++) begin : g_m
        assign cyc_vec[i] = master[i].cyc;
        assign stb_vec[i] = master[i].stb;
        assign we_vec[i]  = master[i].we;
        assign adr_arr[i] = master[i].adr;
        assign dat_arr[i] = master[i].dat_m2s;
        assign sel_arr[i] = master[i].sel;
        assign cti_arr[i] = master[i].cti;
        assign bte_arr[i] = master[i].bte;

        assign is_own[i] = (ptr_q == PW'(i));
        assign grant[i]  = (live | aborting) & is_own[i];

        assign master[i].dat_s2m = (live & is_own[i]) ? slave.dat_s2m : '0;
        assign master[i].ack     = live & is_own[i] & slave.ack;
        assign master[i].err     = is_own[i] & ((live & slave.err) | aborting);
        assign master[i].rty     = live & is_own[i] & slave.rty;
    end

    wb_rr_pick #(
        .N  (MASTERS),
        .IW (PW)
    ) u_pick (
        .req   (cyc_vec),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .pick  (pick_idx)
    );

    always_comb begin
        slave.cyc     = 1'b0;
        slave.stb     = 1'b0;
        slave.we      = 1'b0;
        slave.adr     = '0;
        slave.dat_m2s = '0;
        slave.sel     = '0;
        slave.cti     = '0;
        slave.bte     = '0;
        if (live) begin
            slave.cyc     = own_cyc;
            slave.stb     = own_stb;
            slave.we      = we_vec[ptr_q];
            slave.adr     = adr_arr[ptr_q];
            slave.dat_m2s = dat_arr[ptr_q];
            slave.sel     = sel_arr[ptr_q];
            slave.cti     = cti_arr[ptr_q];
            slave.bte     = bte_arr[ptr_q];
        end
    end

    // Release is checked before the watchdog, so a dropped CYC beats a firing timer.
    assign unanswered = WD_EN && live && own_cyc && own_stb
                        && !(slave.ack || slave.err || slave.rty);
    assign wd_fire    = unanswered && (wd_q == WD_LAST);
    assign timeout    = aborting;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_OWNED;
                    ptr_d   = pick_idx;
                end
            end
            ST_OWNED: begin
                if (!own_cyc) begin
                    state_d = pick_valid ? ST_OWNED : ST_IDLE;
                    if (pick_valid) ptr_d = pick_idx;
                end else if (wd_fire) begin
                    state_d = ST_ABORT;
                end else if (unanswered) begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (own_cyc) begin
                    state_d = ST_OWNED;
                end else begin
                    state_d = pick_valid ? ST_OWNED : ST_IDLE;
                    if (pick_valid) ptr_d = pick_idx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_rr_b3.sv
// Bench for wb_arbiter_rr_b3: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; a second 5-master build without watchdog.
module tb_wb_arbiter_rr_b3;
    localparam int NM = 3;
    localparam int TO = 8;

    logic clk;
    logic rst_n;

    logic [NM-1:0] m_cyc, m_stb, m_we;
    logic [31:0]   m_adr [NM];
    logic [31:0]   m_dat [NM];
    logic [3:0]    m_sel [NM];
    logic [2:0]    m_cti [NM];
    logic [1:0]    m_bte [NM];
    logic [31:0]   o_dat [NM];
    logic [NM-1:0] o_ack, o_err, o_rty;
    logic          s_ack, s_err, s_rty;
    logic [31:0]   s_dat;
    logic [NM-1:0] grant3;
    logic          tmo3;

    logic          p5_req, p5_on;
    int            p5_cnt;
    logic [4:0]    grant5;
    logic          tmo5;
    logic [4:0]    o5_err;

    int n_cmp, n_bad;

    // behavioural reference state
    int md_owner, md_last, md_wd;
    bit md_abort;

    wishbone_b3 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if [NM] ();
    wishbone_b3 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
    wishbone_b3 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m5_if [5] ();
    wishbone_b3 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s5_if ();

    for (genvar g = 0; g < NM; g++) begin : g_drv
        assign m_if[g].cyc     = m_cyc[g];
        assign m_if[g].stb     = m_stb[g];
        assign m_if[g].we      = m_we[g];
        assign m_if[g].adr     = m_adr[g];
        assign m_if[g].dat_m2s = m_dat[g];
        assign m_if[g].sel     = m_sel[g];
        assign m_if[g].cti     = m_cti[g];
        assign m_if[g].bte     = m_bte[g];
        assign o_dat[g]        = m_if[g].dat_s2m;
        assign o_ack[g]        = m_if[g].ack;
        assign o_err[g]        = m_if[g].err;
        assign o_rty[g]        = m_if[g].rty;
    end
    assign s_if.ack     = s_ack;
    assign s_if.err     = s_err;
    assign s_if.rty     = s_rty;
    assign s_if.dat_s2m = s_dat;

    for (genvar g = 0; g < 5; g++) begin : g_drv5
        assign m5_if[g].cyc     = (g == 4) ? p5_req : 1'b0;
        assign m5_if[g].stb     = (g == 4) ? p5_req : 1'b0;
        assign m5_if[g].we      = 1'b0;
        assign m5_if[g].adr     = 32'h0000_4000;
        assign m5_if[g].dat_m2s = 32'h0;
        assign m5_if[g].sel     = 4'hF;
        assign m5_if[g].cti     = 3'b000;
        assign m5_if[g].bte     = 2'b00;
        assign o5_err[g]        = m5_if[g].err;
    end
    assign s5_if.ack     = 1'b0;
    assign s5_if.err     = 1'b0;
    assign s5_if.rty     = 1'b0;
    assign s5_if.dat_s2m = 32'h0;

    wb_arbiter_rr_b3 #(
        .MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .master(m_if), .slave(s_if),
        .grant(grant3), .timeout(tmo3)
    );

    wb_arbiter_rr_b3 #(
        .MASTERS(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .master(m5_if), .slave(s5_if),
        .grant(grant5), .timeout(tmo5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_from(int from);
        for (int k = 1; k <= NM; k++) begin
            int j;
            j = (from + k) % NM;
            if (m_cyc[j]) return j;
        end
        return -1;
    endfunction

    task automatic mdl_reset();
        md_owner = -1;
        md_abort = 1'b0;
        md_wd    = 0;
        md_last  = NM - 1;
    endtask

    task automatic mdl_release(int from);
        md_owner = rr_from(from);
        if (md_owner >= 0) md_last = md_owner;
        md_wd = 0;
    endtask

    task automatic mdl_step();
        if (md_owner < 0) begin
            mdl_release(md_last);
        end else if (md_abort) begin
            md_abort = 1'b0;
            if (!m_cyc[md_owner]) mdl_release(md_owner);
        end else if (!m_cyc[md_owner]) begin
            mdl_release(md_owner);
        end else if (m_stb[md_owner] && !(s_ack || s_err || s_rty)) begin
            md_wd++;
            if (md_wd == TO) begin
                md_abort = 1'b1;
                md_wd    = 0;
            end
        end else begin
            md_wd = 0;
        end
    endtask

    task automatic compare_all();
        logic [2:0]  eg;
        logic [75:0] es, gs;
        logic [34:0] em;
        int o;
        o  = md_owner;
        eg = '0;
        es = '0;
        if (o >= 0) eg[o] = 1'b1;
        if (o >= 0 && !md_abort)
            es = {m_cyc[o], m_stb[o], m_we[o], m_sel[o], m_cti[o], m_bte[o], m_adr[o], m_dat[o]};
        gs = {s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.cti, s_if.bte, s_if.adr, s_if.dat_m2s};
        chk("grant", grant3, eg);
        chk("timeout", tmo3, md_abort);
        chk("slave_m2s", gs, es);
        for (int i = 0; i < NM; i++) begin
            em = '0;
            if (i == o) em = md_abort ? {1'b0, 1'b1, 1'b0, 32'h0} : {s_ack, s_err, s_rty, s_dat};
            chk($sformatf("mst%0d_s2m", i), {o_ack[i], o_err[i], o_rty[i], o_dat[i]}, em);
        end
    endtask

    task automatic compare5();
        chk("p5_grant", grant5, (p5_cnt == 0) ? 5'b00000 : 5'b10000);
        chk("p5_no_err", {tmo5, o5_err}, 6'b0);
        chk("p5_scyc", s5_if.cyc, p5_cnt != 0);
    endtask

    task automatic tick();
        #2;
        if (!rst_n) mdl_reset();
        compare_all();
        if (p5_on) compare5();
        @(posedge clk);
        if (rst_n) mdl_step(); else mdl_reset();
        if (p5_on) p5_cnt++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < NM; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = 4'hF;
            m_cti[i] = 3'b000; m_bte[i] = 2'b00;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic [NM-1:0] drop, drop_n;
        logic [2:0] fg [8];
        logic       fc [8];
        bit quiet;

        n_cmp = 0; n_bad = 0;
        p5_req = 1'b0; p5_on = 1'b0; p5_cnt = 0;
        mdl_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        #1;
        chk("rst_grant", grant3, 3'b000);
        chk("rst_tmo", tmo3, 1'b0);
        chk("rst_scyc", s_if.cyc, 1'b0);
        tick();
        rst_n = 1'b1;

        // single read
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100;
        #1;
        chk("rd_c0_scyc", s_if.cyc, 1'b0);
        tick();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        #1;
        chk("rd_adr", s_if.adr, 32'h100);
        chk("rd_grant", grant3, 3'b001);
        chk("rd_ack0", {o_ack[0], o_dat[0]}, {1'b1, 32'hDEAD_BEEF});
        chk("rd_m1_quiet", {o_ack[1], o_dat[1]}, 33'h0);
        chk("rd_m2_quiet", {o_ack[2], o_dat[2]}, 33'h0);
        tick();
        clear_inputs();
        tick();
        tick();

        // fairness: each master drops CYC for one cycle after its ACK
        do_reset();
        drop = '0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NM; i++) begin
                m_cyc[i] = !drop[i];
                m_stb[i] = !drop[i];
            end
            s_ack = (drop == '0);
            #1;
            drop_n = o_ack;
            fg[k] = grant3;
            fc[k] = s_if.cyc;
            tick();
            drop = drop_n;
        end
        begin
            logic [2:0] eg8 [8] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
            logic       ec8 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("fair_grant_c%0d", k), fg[k], eg8[k]);
                chk($sformatf("fair_scyc_c%0d", k), fc[k], ec8[k]);
            end
        end
        clear_inputs();
        tick();
        tick();

        // hold: master1 burst while master0 waits
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
            s_ack = 1'b1;
            #1;
            chk($sformatf("hold_grant_b%0d", b), grant3, 3'b010);
            chk($sformatf("hold_cti_b%0d", b), s_if.cti, m_cti[1]);
            tick();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        #1;
        chk("hold_release_grant", grant3, 3'b010);
        chk("hold_release_scyc", s_if.cyc, 1'b0);
        tick();
        #1;
        chk("hold_next_grant", grant3, 3'b001);
        chk("hold_next_scyc", s_if.cyc, 1'b1);
        tick();
        clear_inputs();
        tick();
        tick();

        // watchdog: master2 strobes, slave silent (late ACK during abort)
        do_reset();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        for (c = 0; c < 19; c++) begin
            bit et;
            s_ack = (c == 9);
            et = (c == 9) || (c == 18);
            #1;
            chk($sformatf("wd_pulse_c%0d", c), tmo3, et);
            chk($sformatf("wd_err2_c%0d", c), o_err[2], et);
            chk($sformatf("wd_ack2_c%0d", c), o_ack[2], 1'b0);
            chk($sformatf("wd_scyc_c%0d", c), s_if.cyc, (c >= 1) && !et);
            chk($sformatf("wd_grant_c%0d", c), grant3, (c == 0) ? 3'b000 : 3'b100);
            tick();
        end
        clear_inputs();
        tick();
        tick();

        // reset mid-transfer
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        #1;
        chk("rmt_owned", grant3, 3'b001);
        tick();
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rmt_grant", grant3, 3'b000);
        chk("rmt_scyc", s_if.cyc, 1'b0);
        chk("rmt_ack0", o_ack[0], 1'b0);
        tick();
        s_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rmt_post_idle", grant3, 3'b000);
        tick();
        #1;
        chk("rmt_regrant", grant3, 3'b001);
        tick();
        clear_inputs();
        tick();

        // randomized traffic against the model
        quiet = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            int r;
            if ($urandom_range(15) == 0) quiet = !quiet;
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(11) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    m_cyc[i] = 1'b1;
                end
                m_stb[i] = m_cyc[i] & ($urandom_range(3) != 0);
                m_we[i]  = 1'($urandom);
                m_adr[i] = $urandom;
                m_dat[i] = $urandom;
                m_sel[i] = 4'($urandom);
                m_cti[i] = 3'($urandom);
                m_bte[i] = 2'($urandom);
            end
            r = quiet ? 15 : int'($urandom_range(11));
            s_ack = (r < 3);
            s_err = (r == 3);
            s_rty = (r == 4);
            s_dat = $urandom;
            rst_n = ($urandom_range(199) != 0);
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
        tick();
        tick();

        // 5-master build, watchdog disabled, slave never answers
        p5_on = 1'b1;
        p5_cnt = 0;
        p5_req = 1'b1;
        for (int n = 0; n < 1001; n++) tick();
        p5_req = 1'b0;
        p5_on = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
